ram_dp_init: RTL and testbench

//  Next-generation parametrised simple-dual-port RAM: one write port, one read port, one clock.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_rd_pipe.sv | 58 +++++
 rtl/ram_dp_init.sv | 146 ++++++++++++++
 tb/tb_ram_dp_init.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the simple-dual-port RAM and the agents that drive it.
// Holds the default geometry, the controller state type and word/address/byte-enable types
// sized for the default geometry.
// Optional feature macro RAM_BYPASS_EN is consumed by ram_dp_init, not by this package.
package ram_pkg;

    localparam int unsigned RAM_WIDTH_DEF = 64;
    localparam int unsigned ADDR_SIZE_DEF = 12;
    localparam int unsigned DEPTH_DEF     = 4096;

    typedef enum logic {INIT, READY} ram_state_e;

    typedef logic [RAM_WIDTH_DEF-1:0]   ram_word_t;
    typedef logic [ADDR_SIZE_DEF-1:0]   ram_addr_t;
    typedef logic [RAM_WIDTH_DEF/8-1:0] ram_be_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: LATENCY-deep shift of {data, valid, err}.
// Each data stage only loads when a valid word arrives, so the output word holds its last
// value while valid_o is low. All stages clear on asynchronous reset.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   data_i   read word entering the pipe
//   valid_i  an accepted read enters this cycle
//   err_i    the entering read was out of range
//   data_o   read word leaving the pipe
//   valid_o  one-cycle pulse per accepted read
//   err_o    out-of-range flag, only ever high together with valid_o
module ram_rd_pipe #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             err_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             err_o
);

    logic [WIDTH-1:0]   data_q [LATENCY];
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            valid_q[0] <= valid_i;
            err_q[0]   <= valid_i & err_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign data_o  = data_q[LATENCY-1];
    assign valid_o = valid_q[LATENCY-1];
    assign err_o   = err_q[LATENCY-1];

endmodule

// File: rtl/ram_dp_init.sv
// Parametrised simple-dual-port RAM (one write port, one read port, one clock) with per-byte
// write enables, a 1- or 2-stage registered read return with valid strobe, a post-reset
// memory-clear sequence and out-of-range address detection.
// Build option: define RAM_BYPASS_EN for write-first behaviour on a same-address
// read-during-write; left undefined the read returns the previously stored word.
// Ports:
//   clk         clock, all logic on posedge
//   resetn      asynchronous active-low reset
//   data_in     write data
//   wr_address  write address
//   write       write control
//   byte_en     per-byte write enable, bit i covers data_in[8i+7:8i]
//   rd_address  read address
//   read        read control
//   data_out    read data, qualified by rd_valid
//   rd_valid    one-cycle pulse per accepted read
//   addr_err    pulses with rd_valid when that read was out of range
//   init_done   high when the RAM accepts accesses
module ram_dp_init
    import ram_pkg::*;
#(
    parameter int unsigned          RAM_WIDTH      = RAM_WIDTH_DEF,
    parameter int unsigned          ADDR_SIZE      = ADDR_SIZE_DEF,
    parameter int unsigned          DEPTH          = DEPTH_DEF,
    parameter int unsigned          RD_LATENCY     = 1,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [RAM_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [RAM_WIDTH-1:0]   data_in,
    input  logic [ADDR_SIZE-1:0]   wr_address,
    input  logic                   write,
    input  logic [RAM_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_SIZE-1:0]   rd_address,
    input  logic                   read,
    output logic [RAM_WIDTH-1:0]   data_out,
    output logic                   rd_valid,
    output logic                   addr_err,
    output logic                   init_done
);

    localparam int unsigned          NumBytes = RAM_WIDTH / 8;
    localparam int unsigned          IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_SIZE is representable for the range compare.
    localparam logic [ADDR_SIZE:0]   DepthExt = (ADDR_SIZE + 1)'(DEPTH);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("ram_dp_init: RD_LATENCY must be 1 or 2");
    end
    if (RAM_WIDTH % 8 != 0 || RAM_WIDTH == 0) begin : g_bad_width
        $error("ram_dp_init: RAM_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_SIZE)) begin : g_bad_depth
        $error("ram_dp_init: DEPTH must be in 1 .. 2**ADDR_SIZE");
    end

    ram_state_e           state_q;
    logic [ADDR_SIZE-1:0] init_cnt_q;
    logic [RAM_WIDTH-1:0] mem [DEPTH];

    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [RAM_WIDTH-1:0] rd_word;
    logic [RAM_WIDTH-1:0] rd_data;

    // Addresses are compared unsigned at full width: nothing at or above DEPTH aliases.
    assign wr_in_range = {1'b0, wr_address} < DepthExt;
    assign rd_in_range = {1'b0, rd_address} < DepthExt;
    assign wr_fire     = (state_q == READY) & write & wr_in_range;
    assign rd_fire     = (state_q == READY) & read;
    assign init_done   = (state_q == READY);

    // Clear sequence: one location per cycle, READY once the last location is written.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= CLEAR_ON_RESET ? INIT : READY;
            init_cnt_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LastAddr) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q <= READY;
                end
            endcase
        end
    end

    // Storage carries no reset; its contents are defined by the clear sequence.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[init_cnt_q[IdxW-1:0]] <= INIT_VALUE;
        end else if (wr_fire) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (byte_en[b]) begin
                    mem[wr_address[IdxW-1:0]][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[rd_address[IdxW-1:0]];

    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = rd_word;
`ifdef RAM_BYPASS_EN
            // Write-first: enabled bytes of a colliding write are forwarded from data_in.
            if (wr_fire && (wr_address == rd_address)) begin
                for (int b = 0; b < NumBytes; b++) begin
                    if (byte_en[b]) begin
                        rd_data[8*b +: 8] = data_in[8*b +: 8];
                    end
                end
            end
`endif
        end
    end

    ram_rd_pipe #(
        .WIDTH   (RAM_WIDTH),
        .LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .data_i  (rd_data),
        .valid_i (rd_fire),
        .err_i   (~rd_in_range),
        .data_o  (data_out),
        .valid_o (rd_valid),
        .err_o   (addr_err)
    );

endmodule

// File: tb/tb_ram_dp_init.sv
// Directed bench for ram_dp_init: two instances (read latency 1 and 2) share one stimulus
// stream; expected read returns are queued per instance with the cycle they are due.
module tb_ram_dp_init;
    import ram_pkg::*;

    localparam int unsigned W = 64;
    localparam int unsigned A = 12;
    localparam int unsigned D = 16;

    typedef struct packed {
        logic [31:0]  due;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [A-1:0] wr_address = '0;
    logic         write = 1'b0;
    logic [7:0]   byte_en = '0;
    logic [A-1:0] rd_address = '0;
    logic         read = 1'b0;

    logic [W-1:0] dout [2];
    logic         vld  [2];
    logic         aerr [2];
    logic         idone [2];

    exp_t         q [2][$];
    logic [W-1:0] model [D];
    logic [W-1:0] last [2];
    int unsigned  cyc = 0;
    int unsigned  rel_cyc = 32'h4000_0000;
    int           vectors = 0;
    int           miscompares = 0;

    ram_dp_init #(
        .RAM_WIDTH(W), .ADDR_SIZE(A), .DEPTH(D), .RD_LATENCY(1),
        .CLEAR_ON_RESET(1'b1), .INIT_VALUE('0)
    ) u_lat1 (
        .clk(clk), .resetn(resetn), .data_in(data_in), .wr_address(wr_address),
        .write(write), .byte_en(byte_en), .rd_address(rd_address), .read(read),
        .data_out(dout[0]), .rd_valid(vld[0]), .addr_err(aerr[0]), .init_done(idone[0])
    );

    ram_dp_init #(
        .RAM_WIDTH(W), .ADDR_SIZE(A), .DEPTH(D), .RD_LATENCY(2),
        .CLEAR_ON_RESET(1'b1), .INIT_VALUE('0)
    ) u_lat2 (
        .clk(clk), .resetn(resetn), .data_in(data_in), .wr_address(wr_address),
        .write(write), .byte_en(byte_en), .rd_address(rd_address), .read(read),
        .data_out(dout[1]), .rd_valid(vld[1]), .addr_err(aerr[1]), .init_done(idone[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: every cycle each instance either returns the queued head or stays idle
    // with data_out holding its previous value.
    always @(negedge clk) begin
        if (resetn) begin
            for (int k = 0; k < 2; k++) begin
                logic ev;
                ev = (q[k].size() > 0) && (q[k][0].due == cyc);
                chk($sformatf("rd_valid_l%0d@%0d", k + 1, cyc), W'(vld[k]), W'(ev));
                if (ev) begin
                    chk($sformatf("data_out_l%0d@%0d", k + 1, cyc), dout[k], q[k][0].data);
                    chk($sformatf("addr_err_l%0d@%0d", k + 1, cyc), W'(aerr[k]), W'(q[k][0].err));
                    last[k] = q[k][0].data;
                    void'(q[k].pop_front());
                end else begin
                    chk($sformatf("hold_l%0d@%0d", k + 1, cyc), dout[k], last[k]);
                    chk($sformatf("err_idle_l%0d@%0d", k + 1, cyc), W'(aerr[k]), '0);
                end
            end
        end
    end

    // Drive one cycle of stimulus (called just after a negedge) and record its expectation.
    task automatic drive(input logic w, input logic [A-1:0] wa, input logic [W-1:0] wd,
                         input logic [7:0] be, input logic r, input logic [A-1:0] ra);
        logic ready;
        exp_t e;
        write = w; wr_address = wa; data_in = wd; byte_en = be;
        read = r; rd_address = ra;
        ready = resetn && (cyc >= rel_cyc + 16);
        if (ready && r) begin
            e.err  = (ra >= D);
            e.data = '0;
            if (ra < D) begin
                e.data = model[ra[3:0]];
`ifdef RAM_BYPASS_EN
                if (w && wa == ra) begin
                    for (int b = 0; b < 8; b++) if (be[b]) e.data[8*b +: 8] = wd[8*b +: 8];
                end
`endif
            end
            e.due = cyc + 1; q[0].push_back(e);
            e.due = cyc + 2; q[1].push_back(e);
        end
        if (ready && w && wa < D) begin
            for (int b = 0; b < 8; b++) if (be[b]) model[wa[3:0]][8*b +: 8] = wd[8*b +: 8];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd(input logic [A-1:0] ra);
        drive(1'b0, '0, '0, '0, 1'b1, ra);
    endtask

    task automatic wr(input logic [A-1:0] wa, input logic [W-1:0] wd, input logic [7:0] be);
        drive(1'b1, wa, wd, be, 1'b0, '0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next clock edge.
    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        rel_cyc = 32'h4000_0000;
        q[0].delete(); q[1].delete();
        last[0] = '0; last[1] = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_dout_l%0d", tag, k + 1), dout[k], '0);
            chk($sformatf("%s_vld_l%0d", tag, k + 1), W'(vld[k]), '0);
            chk($sformatf("%s_err_l%0d", tag, k + 1), W'(aerr[k]), '0);
            chk($sformatf("%s_idone_l%0d", tag, k + 1), W'(idone[k]), '0);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        resetn = 1'b1;
        rel_cyc = cyc;
        for (int i = 0; i < D; i++) model[i] = '0;
    endtask

    // Count cycles from reset release until init_done; a stray write and read go in early.
    task automatic wait_init(input string tag);
        int n;
        for (n = 1; n <= 40; n++) begin
            if (n == 5) drive(1'b1, 12'd4, {8{8'h55}}, 8'hFF, 1'b1, 12'd6);
            else idle(1);
            if (idone[0]) break;
        end
        chk($sformatf("%s_init_cycles", tag), W'(n), W'(16));
        chk($sformatf("%s_idone_l2", tag), W'(idone[1]), W'(1'b1));
    endtask

    initial begin
        last[0] = '0; last[1] = '0;
        for (int i = 0; i < D; i++) model[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_dout_l%0d", k + 1), dout[k], '0);
            chk($sformatf("rst_vld_l%0d", k + 1), W'(vld[k]), '0);
            chk($sformatf("rst_idone_l%0d", k + 1), W'(idone[k]), '0);
        end

        // Reset asserted in cycle 8 of INIT; accesses during INIT are ignored
        release_reset();
        for (int n = 1; n <= 8; n++) begin
            if (n == 3) drive(1'b1, 12'd4, {8{8'h33}}, 8'hFF, 1'b1, 12'd2);
            else idle(1);
        end
        async_reset("mid_init");
        release_reset();
        wait_init("init1");

        // Cleared contents
        rd(12'd5);
        rd(12'd4);

        // Full and single-byte writes, byte_en=0 no-op
        wr(12'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        rd(12'd3);
        wr(12'd3, '1, 8'h01);
        rd(12'd3);
        wr(12'd3, '0, 8'h00);
        rd(12'd3);

        // Back-to-back reads
        wr(12'd0, 64'hA0A0_0000_0000_0001, 8'hFF);
        wr(12'd1, 64'hA1A1_0000_0000_0002, 8'hFF);
        wr(12'd2, 64'hA2A2_0000_0000_0003, 8'hFF);
        rd(12'd0);
        rd(12'd1);
        rd(12'd2);
        idle(1);

        // Same-address read during write, full and partial byte enables
        wr(12'd7, {8{8'h11}}, 8'hFF);
        drive(1'b1, 12'd7, {8{8'hAA}}, 8'hFF, 1'b1, 12'd7);
        rd(12'd7);
        drive(1'b1, 12'd7, {8{8'h22}}, 8'h0F, 1'b1, 12'd7);
        rd(12'd7);

        // Out-of-range write dropped, read flagged, no aliasing onto addr 4
        wr(12'd4, 64'h4444_4444_4444_4444, 8'hFF);
        wr(12'd20, 64'h9999_9999_9999_9999, 8'hFF);
        rd(12'd20);
        rd(12'd4);
        rd(12'hFFF);
        rd(12'd16);
        rd(12'd15);

        // Independent ports at different addresses
        drive(1'b1, 12'd9, 64'h0909_0909_5A5A_5A5A, 8'hF0, 1'b1, 12'd3);
        rd(12'd9);
        rd(12'd3);

        // Reset during READY with a read still in flight in the 2-stage pipe
        async_reset("mid_ready");
        release_reset();
        wait_init("init2");
        rd(12'd3);
        rd(12'd7);
        idle(4);

        chk("queue_l1_drained", W'(q[0].size()), '0);
        chk("queue_l2_drained", W'(q[1].size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
